// File: rtl/vis_arbiter.sv
// Round-robin arbiter that forwards whole visibility frames from one of COUNT
// requesters to a single accumulator port through a one-beat output register.
// Optional burst watchdog is compiled in with `define VIS_ARBITER_WATCHDOG_EN.
module vis_arbiter #(
  parameter int unsigned COUNT   = 24,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SBITS   = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [COUNT-1:0]       s_tvalid,
  output logic [COUNT-1:0]       s_tready,
  input  logic [COUNT-1:0]       s_tfirst,
  input  logic [COUNT-1:0]       s_tlast,
  input  logic [COUNT*WIDTH-1:0] s_revis,
  input  logic [COUNT*WIDTH-1:0] s_imvis,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tfirst,
  output logic                   m_tlast,
  output logic [SBITS-1:0]       m_tsrc,
  output logic [WIDTH-1:0]       m_revis,
  output logic [WIDTH-1:0]       m_imvis,
  output logic                   timeout_o
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           r_state, w_state_d;
  logic [SBITS-1:0] r_ptr, w_ptr_d;
  logic [SBITS-1:0] r_grant, w_grant_d;

  logic             r_m_tvalid, r_m_tfirst, r_m_tlast;
  logic [SBITS-1:0] r_m_tsrc;
  logic [WIDTH-1:0] r_m_revis, r_m_imvis;

  logic [COUNT-1:0] w_req_rot;
  logic             w_found;
  logic [SBITS-1:0] w_pick;
  int               w_sum;

  logic             w_gvalid, w_gfirst, w_glast;
  logic [WIDTH-1:0] w_grev, w_gim;
  logic [COUNT-1:0] w_onehot;
  logic             w_out_ready;
  logic             w_accept;
  logic             w_abort;
  logic [SBITS-1:0] w_grant_inc;

  // Requests rotated so that bit 0 is the requester at ptr.
  assign w_req_rot = COUNT'({s_tvalid, s_tvalid} >> r_ptr);

  // First valid requester at or after ptr, modulo COUNT.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = 0;
    for (int i = 0; i < COUNT; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_sum   = int'(r_ptr) + i;
        if (w_sum >= int'(COUNT)) w_sum = w_sum - int'(COUNT);
        w_pick  = SBITS'(w_sum);
      end
    end
  end

  // Select the granted requester's beat and build its one-hot ready mask.
  always_comb begin
    w_gvalid = 1'b0;
    w_gfirst = 1'b0;
    w_glast  = 1'b0;
    w_grev   = '0;
    w_gim    = '0;
    w_onehot = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (r_grant == SBITS'(i)) begin
        w_gvalid    = s_tvalid[i];
        w_gfirst    = s_tfirst[i];
        w_glast     = s_tlast[i];
        w_grev      = s_revis[i*WIDTH +: WIDTH];
        w_gim       = s_imvis[i*WIDTH +: WIDTH];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Output register can take a beat when empty or draining this cycle.
  assign w_out_ready = !r_m_tvalid || m_tready;
  assign s_tready    = (r_state == StBurst && w_out_ready) ? w_onehot : '0;
  assign w_accept    = (r_state == StBurst) && w_out_ready && w_gvalid;
  assign w_grant_inc = (r_grant == SBITS'(COUNT - 1)) ? '0 : r_grant + 1'b1;

`ifdef VIS_ARBITER_WATCHDOG_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_timeout;

  // Abort on the TIMEOUT-th consecutive cycle the granted source is idle.
  assign w_abort = (r_state == StBurst) && !w_gvalid && (r_stall == STALL_W'(TIMEOUT - 1));

  // Stall counter: runs only while the granted source withholds valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (r_state != StBurst || w_gvalid || w_abort) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= 1'b0;
    end else if (w_abort) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_abort   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state: grant in IDLE, release on last beat (or watchdog abort).
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_grant_d = r_grant;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_d = w_pick;
          w_state_d = StBurst;
        end
      end
      StBurst: begin
        if ((w_accept && w_glast) || w_abort) begin
          w_state_d = StIdle;
          w_ptr_d   = w_grant_inc;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_grant <= w_grant_d;
    end
  end

  // Output beat register: load on accept, drop valid once consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tfirst <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tsrc   <= '0;
      r_m_revis  <= '0;
      r_m_imvis  <= '0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tfirst <= w_gfirst;
      r_m_tlast  <= w_glast;
      r_m_tsrc   <= r_grant;
      r_m_revis  <= w_grev;
      r_m_imvis  <= w_gim;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tvalid = r_m_tvalid;
  assign m_tfirst = r_m_tfirst;
  assign m_tlast  = r_m_tlast;
  assign m_tsrc   = r_m_tsrc;
  assign m_revis  = r_m_revis;
  assign m_imvis  = r_m_imvis;

endmodule

// File: tb/tb_vis_arbiter.sv
// Directed testbench for vis_arbiter (default 24 requesters, 16-bit parts).
// Honours VIS_ARBITER_WATCHDOG_EN for the watchdog scenario.
module tb_vis_arbiter;
  localparam int COUNT = 24;
  localparam int WIDTH = 16;
  localparam int SBITS = 5;
  localparam int IW    = 5;
`ifdef VIS_ARBITER_WATCHDOG_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif
  localparam int OW = 2*WIDTH + SBITS + 3;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic [COUNT-1:0]       s_tvalid, s_tready, s_tfirst, s_tlast;
  logic [COUNT*WIDTH-1:0] s_revis, s_imvis;
  logic                   m_tvalid, m_tready, m_tfirst, m_tlast, timeout_o;
  logic [SBITS-1:0]       m_tsrc;
  logic [WIDTH-1:0]       m_revis, m_imvis;

  logic                   tv[COUNT], tf[COUNT], tl[COUNT];
  logic [WIDTH-1:0]       rv[COUNT];

  int checks = 0;
  int errors = 0;

  logic [OW-1:0]    got, exp;
  logic [COUNT-1:0] acc;
  logic             bc[COUNT];

  vis_arbiter #(.COUNT(COUNT), .WIDTH(WIDTH), .SBITS(SBITS), .TIMEOUT(TMO)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tfirst (s_tfirst),
    .s_tlast  (s_tlast),
    .s_revis  (s_revis),
    .s_imvis  (s_imvis),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tfirst (m_tfirst),
    .m_tlast  (m_tlast),
    .m_tsrc   (m_tsrc),
    .m_revis  (m_revis),
    .m_imvis  (m_imvis),
    .timeout_o(timeout_o)
  );

  always #5 clock = ~clock;

  // Pack per-requester stimulus arrays onto the flat DUT buses.
  always_comb begin
    s_tvalid = '0;
    s_tfirst = '0;
    s_tlast  = '0;
    s_revis  = '0;
    s_imvis  = '0;
    for (int i = 0; i < COUNT; i++) begin
      s_tvalid[i] = tv[i];
      s_tfirst[i] = tf[i];
      s_tlast[i]  = tl[i];
      s_revis[i*WIDTH +: WIDTH] = rv[i];
      s_imvis[i*WIDTH +: WIDTH] = ~rv[i];
    end
  end

  assign got = {m_tvalid, m_tfirst, m_tlast, m_tsrc, m_revis, m_imvis};

  function automatic logic [WIDTH-1:0] rev_of(input int i, input int b);
    return WIDTH'(i * 256 + b);
  endfunction

  function automatic logic [COUNT-1:0] bit_of(input int i);
    logic [COUNT-1:0] m;
    m = '0;
    m[IW'(i)] = 1'b1;
    return m;
  endfunction

  function automatic logic [OW-1:0] beat_exp(input int i, input int b, input logic f,
                                             input logic l);
    return {1'b1, f, l, SBITS'(i), rev_of(i, b), ~rev_of(i, b)};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_beat(input int i, input int b, input logic f, input logic l);
    tv[i] = 1'b1;
    tf[i] = f;
    tl[i] = l;
    rv[i] = rev_of(i, b);
  endtask

  task automatic clr_req(input int i);
    tv[i] = 1'b0;
    tf[i] = 1'b0;
    tl[i] = 1'b0;
  endtask

  task automatic do_reset;
    reset_n  = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < COUNT; i++) begin
      clr_req(i);
      rv[i] = '0;
    end
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < COUNT; i++) begin
      clr_req(i);
      rv[i] = '0;
    end
    tick;
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    checks++;
    if ({s_tready, timeout_o} !== '0) begin
      errors++;
      $display("FAIL reset_ready_timeout: got %h/%b want 0/0", s_tready, timeout_o);
    end
    tick;
    reset_n = 1'b1;
    // First cycle after release is arbitration only.
    set_beat(4, 0, 1'b1, 1'b1);
    settle;
    checks++;
    if (s_tready !== '0) begin
      errors++;
      $display("FAIL reset_release_ready: got %h want 0", s_tready);
    end
    tick;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_no_beat: got %b want 0", m_tvalid);
    end
    tick;
    clr_req(4);
    tick;
  endtask

  task automatic test_single;
    do_reset;
    set_beat(3, 0, 1'b1, 1'b0);
    settle;
    checks++;
    if (s_tready !== '0) begin
      errors++;
      $display("FAIL single_idle_ready: got %h want 0", s_tready);
    end
    tick;
    for (int b = 0; b < 4; b++) begin
      set_beat(3, b, b == 0, b == 3);
      settle;
      checks++;
      if (s_tready !== bit_of(3)) begin
        errors++;
        $display("FAIL single_ready_b%0d: got %h want %h", b, s_tready, bit_of(3));
      end
      tick;
      exp = beat_exp(3, b, b == 0, b == 3);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_beat%0d: got %h want %h", b, got, exp);
      end
    end
    clr_req(3);
    settle;
    checks++;
    if (s_tready !== '0) begin
      errors++;
      $display("FAIL single_bubble_ready: got %h want 0", s_tready);
    end
    tick;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got %b want 0", m_tvalid);
    end
    // ptr is now 4: of requesters 2 and 5, 5 wins.
    set_beat(2, 0, 1'b1, 1'b1);
    set_beat(5, 0, 1'b1, 1'b1);
    tick;
    checks++;
    if (s_tready !== bit_of(5)) begin
      errors++;
      $display("FAIL single_next_ptr: got %h want %h", s_tready, bit_of(5));
    end
    tick;
    clr_req(2);
    clr_req(5);
    exp = beat_exp(5, 0, 1'b1, 1'b1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL single_next_beat: got %h want %h", got, exp);
    end
    tick;
  endtask

  task automatic test_fairness;
    int src;
    int bt;
    do_reset;
    for (int i = 0; i < COUNT; i++) begin
      bc[i] = 1'b0;
      set_beat(i, 0, 1'b1, 1'b0);
    end
    for (int k = 1; k <= 75; k++) begin
      settle;
      acc = s_tready & s_tvalid;
      tick;
      for (int i = 0; i < COUNT; i++) begin
        if (acc[IW'(i)]) begin
          bc[i] = ~bc[i];
          set_beat(i, int'(bc[i]), !bc[i], bc[i]);
        end
      end
      if (k % 3 == 1) begin
        checks++;
        if (m_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL fair_bubble_k%0d: got %b want 0", k, m_tvalid);
        end
      end else begin
        bt  = (k % 3 == 2) ? 0 : 1;
        src = ((k - 2 - bt) / 3) % COUNT;
        exp = beat_exp(src, bt, bt == 0, bt == 1);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL fair_k%0d: got %h want %h", k, got, exp);
        end
      end
    end
    for (int i = 0; i < COUNT; i++) clr_req(i);
    tick;
  endtask

  task automatic test_wrap;
    do_reset;
    set_beat(23, 0, 1'b1, 1'b1);
    tick;
    checks++;
    if (s_tready !== bit_of(23)) begin
      errors++;
      $display("FAIL wrap_grant23: got %h want %h", s_tready, bit_of(23));
    end
    tick;
    clr_req(23);
    set_beat(0, 0, 1'b1, 1'b1);
    set_beat(22, 0, 1'b1, 1'b1);
    tick;
    checks++;
    if (s_tready !== bit_of(0)) begin
      errors++;
      $display("FAIL wrap_grant0: got %h want %h", s_tready, bit_of(0));
    end
    tick;
    clr_req(0);
    exp = beat_exp(0, 0, 1'b1, 1'b1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wrap_beat0: got %h want %h", got, exp);
    end
    tick;
    checks++;
    if (s_tready !== bit_of(22)) begin
      errors++;
      $display("FAIL wrap_grant22: got %h want %h", s_tready, bit_of(22));
    end
    tick;
    clr_req(22);
    exp = beat_exp(22, 0, 1'b1, 1'b1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wrap_beat22: got %h want %h", got, exp);
    end
    tick;
  endtask

  task automatic test_backpressure;
    set_beat(9, 0, 1'b1, 1'b0);
    tick;
    tick;
    set_beat(9, 1, 1'b0, 1'b0);
    tick;
    m_tready = 1'b0;
    set_beat(9, 2, 1'b0, 1'b0);
    settle;
    checks++;
    if (s_tready !== '0) begin
      errors++;
      $display("FAIL bp_ready_low: got %h want 0", s_tready);
    end
    exp = beat_exp(9, 1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if (got !== exp || s_tready !== '0) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got %h/%h want %h/0", c, got, s_tready, exp);
      end
    end
    m_tready = 1'b1;
    settle;
    checks++;
    if (s_tready !== bit_of(9)) begin
      errors++;
      $display("FAIL bp_ready_resume: got %h want %h", s_tready, bit_of(9));
    end
    tick;
    exp = beat_exp(9, 2, 1'b0, 1'b0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL bp_beat2: got %h want %h", got, exp);
    end
    set_beat(9, 3, 1'b0, 1'b1);
    tick;
    clr_req(9);
    exp = beat_exp(9, 3, 1'b0, 1'b1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL bp_beat3: got %h want %h", got, exp);
    end
    tick;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got %b want 0", m_tvalid);
    end
  endtask

  task automatic test_reset_mid;
    set_beat(7, 0, 1'b1, 1'b0);
    tick;
    tick;
    set_beat(7, 1, 1'b0, 1'b0);
    tick;
    set_beat(7, 2, 1'b0, 1'b0);
    settle;
    reset_n = 1'b0;
    settle;
    checks++;
    if (got !== '0 || s_tready !== '0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got %h/%h/%b want 0/0/0", got, s_tready, timeout_o);
    end
    set_beat(0, 0, 1'b1, 1'b1);
    set_beat(7, 0, 1'b1, 1'b0);
    tick;
    reset_n = 1'b1;
    settle;
    checks++;
    if (s_tready !== '0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: got %h/%b want 0/0", s_tready, m_tvalid);
    end
    tick;
    checks++;
    if (s_tready !== bit_of(0)) begin
      errors++;
      $display("FAIL midreset_grant0: got %h want %h", s_tready, bit_of(0));
    end
    tick;
    clr_req(0);
    clr_req(7);
    exp = beat_exp(0, 0, 1'b1, 1'b1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midreset_beat0: got %h want %h", got, exp);
    end
    tick;
  endtask

  task automatic test_watchdog;
    set_beat(5, 0, 1'b1, 1'b0);
    tick;
    tick;
    set_beat(5, 1, 1'b0, 1'b0);
    tick;
    clr_req(5);
`ifdef VIS_ARBITER_WATCHDOG_EN
    repeat (TMO - 1) tick;
    checks++;
    if (timeout_o !== 1'b0 || s_tready !== bit_of(5)) begin
      errors++;
      $display("FAIL wd_before: got %b/%h want 0/%h", timeout_o, s_tready, bit_of(5));
    end
    tick;
    checks++;
    if (timeout_o !== 1'b1 || s_tready !== '0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL wd_abort: got %b/%h/%b want 1/0/0", timeout_o, s_tready, m_tvalid);
    end
    set_beat(2, 0, 1'b1, 1'b1);
    set_beat(6, 0, 1'b1, 1'b1);
    tick;
    checks++;
    if (s_tready !== bit_of(6)) begin
      errors++;
      $display("FAIL wd_next_grant: got %h want %h", s_tready, bit_of(6));
    end
    tick;
    clr_req(2);
    clr_req(6);
    checks++;
    if (timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky: got %b want 1", timeout_o);
    end
    tick;
`else
    repeat (TMO + 6) tick;
    checks++;
    if (timeout_o !== 1'b0 || s_tready !== bit_of(5) || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL nowd_hold: got %b/%h/%b want 0/%h/0", timeout_o, s_tready, m_tvalid,
               bit_of(5));
    end
    set_beat(5, 2, 1'b0, 1'b0);
    tick;
    exp = beat_exp(5, 2, 1'b0, 1'b0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL nowd_beat2: got %h want %h", got, exp);
    end
    set_beat(5, 3, 1'b0, 1'b1);
    tick;
    clr_req(5);
    exp = beat_exp(5, 3, 1'b0, 1'b1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL nowd_beat3: got %h want %h", got, exp);
    end
    tick;
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_wrap;
    test_backpressure;
    test_reset_mid;
    test_watchdog;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vis_arbiter.md
VIS_ARBITER -- requirements
Module: vis_arbiter

Interface
REQ-001 SHALL have parameter COUNT, default 24: number of requesters (visaccum instances).
REQ-002 SHALL have parameter WIDTH, default 16: partial-sum width per component.
REQ-003 SHALL have parameter SBITS, default 5: width of the source index, at least clog2(COUNT).
REQ-004 SHALL have parameter TIMEOUT, default 64: watchdog stall limit in cycles (used only under REQ-026).
REQ-005 SHALL have ports:
- clock  input  1  all logic on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- s_tvalid  input  COUNT  per-requester beat valid
- s_tready  output  COUNT  per-requester beat accept
- s_tfirst  input  COUNT  per-requester first beat of frame
- s_tlast  input  COUNT  per-requester last beat of frame
- s_revis  input  COUNT*WIDTH  real parts, requester i at bits [i*WIDTH +: WIDTH]
- s_imvis  input  COUNT*WIDTH  imaginary parts, same packing
- m_tvalid  output  1  output beat valid
- m_tready  input  1  downstream (accumulator) accept
- m_tfirst  output  1  forwarded first flag
- m_tlast  output  1  forwarded last flag
- m_tsrc  output  SBITS  index of the granted requester
- m_revis  output  WIDTH  forwarded real part
- m_imvis  output  WIDTH  forwarded imaginary part
- timeout_o  output  1  sticky watchdog flag

Function
REQ-006 SHALL implement states IDLE and BURST.
REQ-007 IDLE: SHALL grant the first index g, scanning ptr, ptr+1, ... modulo COUNT, with s_tvalid[g]=1; grant is registered, state becomes BURST next cycle; no beat is accepted in IDLE.
REQ-008 IDLE with no s_tvalid set: SHALL remain in IDLE, with grant and ptr unchanged.
REQ-009 BURST: s_tready[g] SHALL equal (!m_tvalid || m_tready); all other s_tready bits SHALL be 0.
REQ-010 s_tready SHALL be all-zero in IDLE.
REQ-011 A beat accepted (s_tvalid[g] && s_tready[g]) in cycle t SHALL appear on m_* in cycle t+1 with m_tsrc=g; latency is exactly 1 cycle.
REQ-012 m_tvalid SHALL clear in cycle t+1 when m_tready=1 at t and no new beat is accepted at t.
REQ-013 While m_tvalid=1 and m_tready=0, all m_* SHALL hold stable.
REQ-014 Acceptance of a beat with s_tlast[g]=1 SHALL return state to IDLE and set ptr=(g+1) mod COUNT, wrapping COUNT-1 to 0.
REQ-015 Each burst SHALL be followed by exactly one arbitration bubble cycle in IDLE.
REQ-016 s_tfirst and s_tlast SHALL be forwarded unmodified; the grant SHALL be held from grant until the last beat, regardless of s_tfirst.
REQ-017 s_tvalid[g] low during BURST SHALL stall the burst without releasing the grant (watchdog excepted).
REQ-018 Requests from non-granted sources arriving during BURST SHALL be held off; no request SHALL be lost while its s_tvalid stays high.
REQ-019 Fairness: with all COUNT requesters continuously valid, grants SHALL cycle 0,1,...,COUNT-1,0.
REQ-020 COUNT=1 SHALL be supported; g is always 0.

Reset
REQ-021 reset_n low SHALL asynchronously force: state=IDLE, ptr=0, g=0, m_tvalid=0, m_tfirst=0, m_tlast=0, m_tsrc=0, m_revis=0, m_imvis=0, timeout_o=0, s_tready=0.
REQ-022 Reset asserted mid-burst SHALL discard the burst; after release, arbitration SHALL restart from index 0.
REQ-023 Release of reset SHALL take effect on the next rising clock edge; no beat SHALL be accepted in that first cycle.

Configuration
REQ-024 Macro VIS_ARBITER_WATCHDOG_EN SHALL compile in the burst watchdog.
REQ-025 Without the macro, timeout_o SHALL be tied to 0 and no stall counter SHALL exist.
REQ-026 With the macro, in BURST with s_tvalid[g]=0 for TIMEOUT consecutive cycles:
- state SHALL return to IDLE
- ptr SHALL become (g+1) mod COUNT
- timeout_o SHALL set and stay set until reset
- no beat SHALL be emitted for the aborted remainder
REQ-027 With the macro, the stall counter SHALL clear on any accepted beat and on entry to BURST.

Verification
REQ-028 Requester 3 only, 4-beat frame, m_tready=1 -> one IDLE cycle, then 4 beats on m_* each 1 cycle after acceptance, m_tsrc=3, m_tfirst on beat 0, m_tlast on beat 3, then ptr=4.
REQ-029 All 24 requesters valid, 2-beat frames -> m_tsrc order 0..23,0; 3-cycle period per grant.
REQ-030 Requester 23 granted, then requesters 0 and 22 valid -> next grant 0 (wrap), then 22.
REQ-031 m_tready low 5 cycles mid-frame -> m_* held stable, s_tready[g]=0, no beat dropped or duplicated.
REQ-032 Reset pulse during beat 2 of a 4-beat frame from requester 7 -> all outputs zero; with requesters 0 and 7 valid after release, first grant is 0.
REQ-033 With VIS_ARBITER_WATCHDOG_EN and TIMEOUT=8, requester 5 drops valid after beat 1 -> after 8 cycles state is IDLE, timeout_o=1, next grant starts search at index 6; without the macro the grant is held indefinitely.
